// File: rtl/nw_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nw_pkg
// Description : Shared constants and types for the Needleman-Wunsch engine.
//               The arrow codes are also used by the per-cell max/arrow unit,
//               so their values must not change independently.
// Revision    : 1.0 - initial release
// ============================================================================
package nw_pkg;

    // One-hot arrow codes as written into the arrow RAM
    localparam logic [2:0] ARROW_LX   = 3'b100;
    localparam logic [2:0] ARROW_UP   = 3'b010;
    localparam logic [2:0] ARROW_DIAG = 3'b001;

    // Gap marker in an aligned column (bit 2 set, never a nucleotide)
    localparam logic [2:0] GAP = 3'b100;

    // 2-bit nucleotide codes
    localparam logic [1:0] NT_A = 2'd0;
    localparam logic [1:0] NT_C = 2'd1;
    localparam logic [1:0] NT_G = 2'd2;
    localparam logic [1:0] NT_T = 2'd3;

    // Traceback controller states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } tb_state_e;

    // True only for one of the three legal arrow codes
    function automatic logic is_arrow(input logic [2:0] a);
        return (a == ARROW_LX) || (a == ARROW_UP) || (a == ARROW_DIAG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nw_tb_step.sv
`default_nettype none
// ============================================================================
// Module      : nw_tb_step
// Description : Combinational single step of the traceback walk. Given the
//               current cell (i,j) and the arrow taken from it, produces the
//               aligned column and the next cell.
// Ports       : move_i            arrow taken (one-hot, nw_pkg coding)
//               i_i, j_i          current cell indices
//               seq_a_i, seq_b_i  packed sequences, char k at [2k-1:2k-2]
//               out_a_o, out_b_o  column symbols ({0,code} or GAP)
//               next_i_o/next_j_o cell reached after the move
//               is_last_o         next cell is (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module nw_tb_step
    import nw_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int IDX_W = 4
) (
    input  logic [2:0]       move_i,
    input  logic [IDX_W-1:0] i_i,
    input  logic [IDX_W-1:0] j_i,
    input  logic [2*N-1:0]   seq_a_i,
    input  logic [2*M-1:0]   seq_b_i,
    output logic [2:0]       out_a_o,
    output logic [2:0]       out_b_o,
    output logic [IDX_W-1:0] next_i_o,
    output logic [IDX_W-1:0] next_j_o,
    output logic             is_last_o
);

    logic [1:0] w_char_a;
    logic [1:0] w_char_b;

    // Character lookup by 1-based index; index 0 selects nothing and is never
    // used for a payload because the boundary moves avoid that sequence.
    always_comb begin
        w_char_a = 2'd0;
        for (int k = 0; k < N; k++) begin
            if (i_i == IDX_W'(k + 1)) w_char_a = seq_a_i[2*k +: 2];
        end
    end

    always_comb begin
        w_char_b = 2'd0;
        for (int k = 0; k < M; k++) begin
            if (j_i == IDX_W'(k + 1)) w_char_b = seq_b_i[2*k +: 2];
        end
    end

    always_comb begin
        out_a_o  = GAP;
        out_b_o  = GAP;
        next_i_o = i_i;
        next_j_o = j_i;
        case (move_i)
            ARROW_DIAG: begin
                out_a_o  = {1'b0, w_char_a};
                out_b_o  = {1'b0, w_char_b};
                next_i_o = i_i - IDX_W'(1);
                next_j_o = j_i - IDX_W'(1);
            end
            ARROW_UP: begin
                out_a_o  = {1'b0, w_char_a};
                next_i_o = i_i - IDX_W'(1);
            end
            ARROW_LX: begin
                out_b_o  = {1'b0, w_char_b};
                next_j_o = j_i - IDX_W'(1);
            end
            default: ;
        endcase
    end

    assign is_last_o = (next_i_o == '0) && (next_j_o == '0);

endmodule
`default_nettype wire

// File: rtl/nw_traceback.sv
`default_nettype none
// ============================================================================
// Module      : nw_traceback
// Description : Traceback stage of the Needleman-Wunsch engine. Walks the
//               stored arrow matrix from (N,M) back to (0,0) and emits one
//               aligned column per beat on a valid/ready stream, end of the
//               alignment first.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               start_i           request a walk (IDLE or ERR only)
//               seq_a_i, seq_b_i  packed sequences
//               sym_addr_o        arrow RAM address {i,j} (registered)
//               sym_re_o          arrow RAM read enable (registered)
//               sym_data_i        arrow read back, valid one cycle after re
//               out_valid_o/out_ready_i  column stream handshake
//               out_a_o, out_b_o, out_move_o, out_last_o  column payload
//               busy_o, done_o, error_o  status
// Revision    : 1.0 - initial release
// ============================================================================
module nw_traceback
    import nw_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2*N-1:0]     seq_a_i,
    input  logic [2*M-1:0]     seq_b_i,
    output logic [2*IDX_W-1:0] sym_addr_o,
    output logic               sym_re_o,
    input  logic [2:0]         sym_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2:0]         out_a_o,
    output logic [2:0]         out_b_o,
    output logic [2:0]         out_move_o,
    output logic               out_last_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o
);

    tb_state_e state_q, state_d;

    logic [IDX_W-1:0]   i_q, j_q;
    logic [IDX_W-1:0]   nxt_i_q, nxt_j_q;
    logic [2*IDX_W-1:0] sym_addr_q;
    logic               sym_re_q;
    logic [2:0]         out_a_q, out_b_q, out_move_q;
    logic               out_last_q;
    logic               error_q;

    // FSM side-effect strobes
    logic       w_begin;
    logic       w_load_emit;
    logic       w_accept;
    logic       w_set_err;
    logic [2:0] w_move;

    logic [2:0]       w_step_a, w_step_b;
    logic [IDX_W-1:0] w_next_i, w_next_j;
    logic             w_step_last;

    nw_tb_step #(
        .N     (N),
        .M     (M),
        .IDX_W (IDX_W)
    ) u_step (
        .move_i    (w_move),
        .i_i       (i_q),
        .j_i       (j_q),
        .seq_a_i   (seq_a_i),
        .seq_b_i   (seq_b_i),
        .out_a_o   (w_step_a),
        .out_b_o   (w_step_b),
        .next_i_o  (w_next_i),
        .next_j_o  (w_next_j),
        .is_last_o (w_step_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        w_begin     = 1'b0;
        w_load_emit = 1'b0;
        w_accept    = 1'b0;
        w_set_err   = 1'b0;
        w_move      = ARROW_DIAG;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_begin = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                busy_o = 1'b1;
                // On a matrix edge only one move is possible, so the RAM is
                // skipped; this also keeps diag away from i==0 / j==0.
                if (j_q == '0) begin
                    w_move      = ARROW_UP;
                    w_load_emit = 1'b1;
                    state_d     = S_EMIT;
                end else if (i_q == '0) begin
                    w_move      = ARROW_LX;
                    w_load_emit = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy_o = 1'b1;
                w_move = sym_data_i;
                if (is_arrow(sym_data_i)) begin
                    w_load_emit = 1'b1;
                    state_d     = S_EMIT;
                end else begin
                    w_set_err = 1'b1;
                    state_d   = S_ERR;
                end
            end
            S_EMIT: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_accept = 1'b1;
                    state_d  = out_last_q ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start_i) begin
                    w_begin = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q        <= '0;
            j_q        <= '0;
            nxt_i_q    <= '0;
            nxt_j_q    <= '0;
            sym_addr_q <= '0;
            sym_re_q   <= 1'b0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            out_move_q <= '0;
            out_last_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // Read enable is a single-cycle strobe covering the FETCH cycle
            sym_re_q <= 1'b0;
            if (w_begin) begin
                i_q        <= IDX_W'(N);
                j_q        <= IDX_W'(M);
                error_q    <= 1'b0;
                sym_addr_q <= {IDX_W'(N), IDX_W'(M)};
                sym_re_q   <= 1'b1;
            end
            // Payload and the post-move cell are captured together so the
            // beat stays stable for as long as the consumer stalls.
            if (w_load_emit) begin
                out_a_q    <= w_step_a;
                out_b_q    <= w_step_b;
                out_move_q <= w_move;
                out_last_q <= w_step_last;
                nxt_i_q    <= w_next_i;
                nxt_j_q    <= w_next_j;
            end
            if (w_accept) begin
                i_q <= nxt_i_q;
                j_q <= nxt_j_q;
                if (!out_last_q) begin
                    sym_addr_q <= {nxt_i_q, nxt_j_q};
                    sym_re_q   <= (nxt_i_q != '0) && (nxt_j_q != '0);
                end
            end
            if (w_set_err) error_q <= 1'b1;
        end
    end

    assign sym_addr_o = sym_addr_q;
    assign sym_re_o   = sym_re_q;
    assign out_a_o    = out_a_q;
    assign out_b_o    = out_b_q;
    assign out_move_o = out_move_q;
    assign out_last_o = out_last_q;
    assign error_o    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_nw_traceback.sv
`default_nettype none
// ============================================================================
// Module      : tb_nw_traceback
// Description : Self-checking bench for nw_traceback. Two instances
//               (2x2 and 2x3) share one clock and reset; each has its own
//               arrow RAM model. Expected beats come from a walk model over
//               the arrow matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nw_traceback;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_s   [2];
    logic       ready_s   [2];
    logic [3:0] seq_a_s   [2];
    logic [5:0] seq_b_s   [2];
    logic [7:0] sym_addr  [2];
    logic       sym_re    [2];
    logic [2:0] sym_data  [2];
    logic       out_valid [2];
    logic [2:0] out_a     [2];
    logic [2:0] out_b     [2];
    logic [2:0] out_move  [2];
    logic       out_last  [2];
    logic       busy      [2];
    logic       done      [2];
    logic       error     [2];

    logic [2:0] arr [2][4][4];

    nw_traceback #(.N(2), .M(2), .IDX_W(4)) u_dut22 (
        .clk(clk), .rst(rst), .start_i(start_s[0]),
        .seq_a_i(seq_a_s[0]), .seq_b_i(seq_b_s[0][3:0]),
        .sym_addr_o(sym_addr[0]), .sym_re_o(sym_re[0]), .sym_data_i(sym_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(ready_s[0]),
        .out_a_o(out_a[0]), .out_b_o(out_b[0]), .out_move_o(out_move[0]),
        .out_last_o(out_last[0]), .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0])
    );

    nw_traceback #(.N(2), .M(3), .IDX_W(4)) u_dut23 (
        .clk(clk), .rst(rst), .start_i(start_s[1]),
        .seq_a_i(seq_a_s[1]), .seq_b_i(seq_b_s[1]),
        .sym_addr_o(sym_addr[1]), .sym_re_o(sym_re[1]), .sym_data_i(sym_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(ready_s[1]),
        .out_a_o(out_a[1]), .out_b_o(out_b[1]), .out_move_o(out_move[1]),
        .out_last_o(out_last[1]), .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1])
    );

    // Synchronous arrow RAMs, latency 1; garbage on idle cycles
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (sym_re[s]) sym_data[s] <= arr[s][sym_addr[s][5:4]][sym_addr[s][1:0]];
            else           sym_data[s] <= 3'($urandom);
        end
    end

    int total = 0;
    int bad   = 0;

    int exp_a[$], exp_b[$], exp_mv[$], exp_last[$], exp_addr[$];
    int exp_err;
    int obs_a[$], obs_b[$], obs_mv[$], obs_last[$], obs_addr[$];
    int obs_err, obs_err1, obs_first, obs_last_acc, obs_done_cyc, obs_done_cnt;
    int obs_done_extra, obs_unstable, obs_busy_end, obs_timeout;

    // Reference walk: follow arrows from (nn,mm), forcing moves on the edges
    task automatic build_model(input int sel, input int nn, input int mm);
        int i, j, ca, cb;
        logic [2:0] mv;
        exp_a.delete(); exp_b.delete(); exp_mv.delete(); exp_last.delete(); exp_addr.delete();
        exp_err = 0;
        i = nn; j = mm;
        while (i > 0 || j > 0) begin
            ca = (i > 0) ? ((int'(seq_a_s[sel]) >> (2*(i-1))) & 3) : 0;
            cb = (j > 0) ? ((int'(seq_b_s[sel]) >> (2*(j-1))) & 3) : 0;
            if (j == 0)      mv = 3'b010;
            else if (i == 0) mv = 3'b100;
            else begin
                exp_addr.push_back(i*16 + j);
                mv = arr[sel][i][j];
                if (mv != 3'b100 && mv != 3'b010 && mv != 3'b001) begin
                    exp_err = 1;
                    break;
                end
            end
            if (mv == 3'b001) begin
                exp_a.push_back(ca); exp_b.push_back(cb); i--; j--;
            end else if (mv == 3'b010) begin
                exp_a.push_back(ca); exp_b.push_back(4); i--;
            end else begin
                exp_a.push_back(4); exp_b.push_back(cb); j--;
            end
            exp_mv.push_back(int'(mv));
            exp_last.push_back((i == 0 && j == 0) ? 1 : 0);
        end
    endtask

    // Start a walk and collect everything the DUT does until DONE or ERR.
    // mode 0: ready high; 1: random ready; 2: 5 stall cycles per beat.
    task automatic run_walk(input int sel, input int mode, input bit pulse);
        int cyc, hold;
        logic [9:0] snap;
        bit have_snap;
        obs_a.delete(); obs_b.delete(); obs_mv.delete(); obs_last.delete(); obs_addr.delete();
        obs_err = 0; obs_err1 = -1; obs_first = -1; obs_last_acc = -1; obs_done_cyc = -1;
        obs_done_cnt = 0; obs_done_extra = 0; obs_unstable = 0; obs_timeout = 1;
        @(negedge clk);
        start_s[sel] = 1'b1;
        ready_s[sel] = (mode == 0);
        cyc = 0; hold = 0; have_snap = 0; snap = '0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            start_s[sel] = (pulse && busy[sel]) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cyc == 1) obs_err1 = int'(error[sel]);
            if (sym_re[sel]) obs_addr.push_back(int'(sym_addr[sel]));
            if (done[sel]) begin
                obs_done_cyc = cyc; obs_done_cnt++; obs_timeout = 0; break;
            end
            if (error[sel] && !busy[sel]) begin
                obs_timeout = 0; break;
            end
            if (out_valid[sel]) begin
                if (obs_first < 0) obs_first = cyc;
                if (have_snap && snap !== {out_a[sel], out_b[sel], out_move[sel], out_last[sel]})
                    obs_unstable++;
                snap = {out_a[sel], out_b[sel], out_move[sel], out_last[sel]};
                have_snap = 1;
                case (mode)
                    0:       ready_s[sel] = 1'b1;
                    1:       ready_s[sel] = 1'($urandom_range(0, 1));
                    default: begin ready_s[sel] = (hold >= 5); hold++; end
                endcase
                if (ready_s[sel]) begin
                    obs_a.push_back(int'(out_a[sel]));
                    obs_b.push_back(int'(out_b[sel]));
                    obs_mv.push_back(int'(out_move[sel]));
                    obs_last.push_back(int'(out_last[sel]));
                    obs_last_acc = cyc; have_snap = 0; hold = 0;
                end
            end else begin
                ready_s[sel] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
        obs_err = int'(error[sel]);
        // A start coinciding with the DONE state must not launch a walk
        if (pulse && obs_done_cnt == 1) start_s[sel] = 1'b1;
        @(negedge clk);
        start_s[sel] = 1'b0;
        ready_s[sel] = 1'b0;
        if (done[sel]) obs_done_extra++;
        obs_busy_end = int'(busy[sel]);
    endtask

    task automatic verify_walk(input string tag);
        int n;
        total++;
        if (obs_timeout != 0) begin
            bad++; $display("FAIL %s timeout: got no DONE/ERR, want one", tag);
        end
        total++;
        if (obs_err != exp_err) begin
            bad++; $display("FAIL %s error: got %0d want %0d", tag, obs_err, exp_err);
        end
        total++;
        if (obs_a.size() != exp_a.size()) begin
            bad++; $display("FAIL %s beats: got %0d want %0d", tag, obs_a.size(), exp_a.size());
        end
        n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int k = 0; k < n; k++) begin
            total++;
            if (obs_a[k] != exp_a[k] || obs_b[k] != exp_b[k]) begin
                bad++; $display("FAIL %s beat%0d a/b: got %0d/%0d want %0d/%0d",
                                tag, k, obs_a[k], obs_b[k], exp_a[k], exp_b[k]);
            end
            total++;
            if (obs_mv[k] != exp_mv[k] || obs_last[k] != exp_last[k]) begin
                bad++; $display("FAIL %s beat%0d move/last: got %0d/%0d want %0d/%0d",
                                tag, k, obs_mv[k], obs_last[k], exp_mv[k], exp_last[k]);
            end
        end
        total++;
        if (obs_addr.size() != exp_addr.size()) begin
            bad++; $display("FAIL %s reads: got %0d want %0d", tag, obs_addr.size(), exp_addr.size());
        end
        n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int k = 0; k < n; k++) begin
            total++;
            if (obs_addr[k] != exp_addr[k]) begin
                bad++; $display("FAIL %s addr%0d: got %h want %h", tag, k, obs_addr[k], exp_addr[k]);
            end
        end
        total++;
        if (obs_done_cnt != (exp_err ? 0 : 1) || obs_done_extra != 0) begin
            bad++; $display("FAIL %s done pulses: got %0d+%0d want %0d",
                            tag, obs_done_cnt, obs_done_extra, exp_err ? 0 : 1);
        end
        if (exp_err == 0) begin
            total++;
            if (obs_done_cyc != obs_last_acc + 1) begin
                bad++; $display("FAIL %s done timing: got cyc %0d want %0d",
                                tag, obs_done_cyc, obs_last_acc + 1);
            end
        end
        total++;
        if (obs_unstable != 0) begin
            bad++; $display("FAIL %s stall stability: got %0d changes want 0", tag, obs_unstable);
        end
        total++;
        if (obs_busy_end != 0) begin
            bad++; $display("FAIL %s busy after walk: got %0d want 0", tag, obs_busy_end);
        end
    endtask

    task automatic fill_diag(input int sel);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                arr[sel][i][j] = 3'b001;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0; ready_s[s] = 1'b0; seq_a_s[s] = '0; seq_b_s[s] = '0;
            fill_diag(s);
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if ({sym_addr[s], sym_re[s], out_valid[s], out_a[s], out_b[s], out_move[s],
                 out_last[s], busy[s], done[s], error[s]} !== '0) begin
                bad++; $display("FAIL reset%0d outputs: got nonzero want 0", s);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_diag();
        seq_a_s[0] = 4'h4;  // "AC"
        seq_b_s[0] = 6'h04;
        fill_diag(0);
        build_model(0, 2, 2);
        run_walk(0, 0, 1'b0);
        verify_walk("diag22");
        total++;
        if (obs_first != 3) begin
            bad++; $display("FAIL diag22 first valid: got cyc %0d want 3", obs_first);
        end
        total++;
        if (obs_done_cyc != 7) begin
            bad++; $display("FAIL diag22 done cycle: got %0d want 7", obs_done_cyc);
        end
    endtask

    task automatic test_left_gap();
        seq_a_s[1] = 4'($urandom);
        seq_b_s[1] = 6'($urandom);
        fill_diag(1);
        arr[1][2][3] = 3'b100;
        build_model(1, 2, 3);
        run_walk(1, 0, 1'b0);
        verify_walk("left23");
    endtask

    task automatic test_boundary();
        seq_a_s[0] = 4'($urandom);
        seq_b_s[0] = 6'($urandom);
        fill_diag(0);
        arr[0][2][2] = 3'b010;
        arr[0][1][2] = 3'b010;
        build_model(0, 2, 2);
        run_walk(0, 0, 1'b0);
        verify_walk("boundary");
        total++;
        if (obs_done_cyc != 11) begin
            bad++; $display("FAIL boundary done cycle: got %0d want 11", obs_done_cyc);
        end
    endtask

    task automatic test_backpressure();
        seq_a_s[0] = 4'h4;
        seq_b_s[0] = 6'h04;
        fill_diag(0);
        build_model(0, 2, 2);
        run_walk(0, 2, 1'b0);
        verify_walk("backpressure");
    endtask

    task automatic test_error();
        fill_diag(0);
        arr[0][2][2] = 3'b000;
        build_model(0, 2, 2);
        run_walk(0, 0, 1'b0);
        verify_walk("err");
        total++;
        if (obs_first != -1) begin
            bad++; $display("FAIL err out_valid seen: got cyc %0d want none", obs_first);
        end
        arr[0][2][2] = 3'b001;
        build_model(0, 2, 2);
        run_walk(0, 0, 1'b0);
        verify_walk("err_restart");
        total++;
        if (obs_err1 != 0) begin
            bad++; $display("FAIL err_restart clear: got error=%0d want 0", obs_err1);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        seq_a_s[0] = 4'h4;
        seq_b_s[0] = 6'h04;
        fill_diag(0);
        @(negedge clk);
        start_s[0] = 1'b1; ready_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        k = 0;
        while (!out_valid[0] && k < 10) begin
            @(negedge clk); k++;
        end
        total++;
        if (!out_valid[0]) begin
            bad++; $display("FAIL rstmid reach EMIT: got valid=0 want 1");
        end
        rst = 1'b1;
        #1;
        total++;
        if ({sym_addr[0], sym_re[0], out_valid[0], out_a[0], out_b[0], out_move[0],
             out_last[0], busy[0], done[0], error[0]} !== '0) begin
            bad++; $display("FAIL rstmid outputs: got nonzero want 0");
        end
        k = 0;
        repeat (3) begin
            @(negedge clk);
            if (done[0]) k++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (done[0]) k++;
        total++;
        if (k != 0) begin
            bad++; $display("FAIL rstmid done pulse: got %0d want 0", k);
        end
        build_model(0, 2, 2);
        run_walk(0, 0, 1'b1);
        verify_walk("busy_start");
    endtask

    task automatic test_random();
        int sel, mm, r;
        logic [2:0] bad_codes [5];
        bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        for (int it = 0; it < 24; it++) begin
            sel = it % 2;
            mm  = (sel == 0) ? 2 : 3;
            seq_a_s[sel] = 4'($urandom);
            seq_b_s[sel] = 6'($urandom);
            for (int i = 1; i <= 2; i++) begin
                for (int j = 1; j <= mm; j++) begin
                    r = $urandom_range(0, 19);
                    if (r == 0)      arr[sel][i][j] = bad_codes[$urandom_range(0, 4)];
                    else if (r < 8)  arr[sel][i][j] = 3'b001;
                    else if (r < 14) arr[sel][i][j] = 3'b010;
                    else             arr[sel][i][j] = 3'b100;
                end
            end
            build_model(sel, 2, mm);
            run_walk(sel, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            verify_walk($sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_diag();
        test_left_gap();
        test_boundary();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
